// File: rtl/sdram_fb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_fb_pkg
// Shared types and defaults for the framebuffer SDRAM client arbiter.
//   ctl_cmd_t   : command encoding driven to the SDRAM controller (3 unused)
//   arb_state_t : arbiter sequencing states
// -----------------------------------------------------------------------------
package sdram_fb_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 22;
   localparam int unsigned DEF_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_READ  = 2'd2
   } ctl_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      WR_WAIT,
      RD_WAIT,
      GAP
   } arb_state_t;

endpackage

// File: rtl/sdram_fb_arb_timeout.sv
// -----------------------------------------------------------------------------
// sdram_fb_arb_timeout
// Loadable completion-wait counter. Cleared by load_i, counts while en_i is
// high, and flags expiry during the LIMIT-th counted cycle so the owner can
// abort on that same edge.
// Ports:
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   load_i    : clear the counter (command granted)
//   en_i      : count this cycle (waiting for completion)
//   expired_o : the current wait cycle is the LIMIT-th one
// -----------------------------------------------------------------------------
module sdram_fb_arb_timeout #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == CW'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sdram_fb_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_fb_arbiter
// Merges the fractal pixel writer (write stream) and the LCD scanout
// prefetcher (read stream) onto the SDRAM controller's single command port.
// One command is issued at a time and held until completion or timeout,
// followed by one NOP gap cycle. Reads win unless MAX_READ_STREAK consecutive
// reads have been granted while a write was pending.
// Optional build macro: FB_ARB_STATS_EN adds stat_reads, stat_writes and
// stat_stall_cycles counters.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data : pixel write request
//   rd_valid/rd_ready/rd_addr       : scanout read request
//   rd_data/rd_data_valid           : returned read word + 1-cycle strobe
//   timeout_err                     : sticky command-timeout flag
//   ctl_command/ctl_address/ctl_write : command to controller (registered)
//   ctl_read/ctl_read_valid/ctl_write_done : completions from controller
// -----------------------------------------------------------------------------
module sdram_fb_arbiter
   import sdram_fb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int unsigned MAX_READ_STREAK = 8,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic                  timeout_err,
   output logic [1:0]            ctl_command,
   output logic [ADDR_WIDTH-1:0] ctl_address,
   output logic [DATA_WIDTH-1:0] ctl_write,
   input  logic [DATA_WIDTH-1:0] ctl_read,
   input  logic                  ctl_read_valid,
   input  logic                  ctl_write_done
`ifdef FB_ARB_STATS_EN
  ,output logic [31:0]           stat_reads,
   output logic [31:0]           stat_writes,
   output logic [31:0]           stat_stall_cycles
`endif
);

   localparam int unsigned SW = $clog2(MAX_READ_STREAK + 1);

   // Reset asserts asynchronously, releases two clk edges after rst_n rises.
   logic [1:0] rst_sync_q;
   logic       arb_rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign arb_rst_n = rst_sync_q[1];

   arb_state_t            state_q, state_d;
   ctl_cmd_t              cmd_q, cmd_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rdv_q, rdv_d;
   logic                  terr_q, terr_d;
   logic [SW-1:0]         streak_q, streak_d;

   logic rd_grant, wr_grant;
   logic tmo_load, tmo_en, tmo_expired;

   sdram_fb_arb_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk),
      .rst_ni    (arb_rst_n),
      .load_i    (tmo_load),
      .en_i      (tmo_en),
      .expired_o (tmo_expired)
   );

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rdv_d    = 1'b0;
      terr_d   = terr_q;
      streak_d = streak_q;
      rd_grant = 1'b0;
      wr_grant = 1'b0;
      tmo_load = 1'b0;
      tmo_en   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rd_valid && (!wr_valid || (streak_q < SW'(MAX_READ_STREAK)))) begin
               rd_grant = 1'b1;
               tmo_load = 1'b1;
               cmd_d    = CMD_READ;
               addr_d   = rd_addr;
               state_d  = RD_WAIT;
               // streak only accumulates while a write is being held off
               if (!wr_valid) begin
                  streak_d = '0;
               end else if (streak_q < SW'(MAX_READ_STREAK)) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (wr_valid) begin
               wr_grant = 1'b1;
               tmo_load = 1'b1;
               cmd_d    = CMD_WRITE;
               addr_d   = wr_addr;
               wdata_d  = wr_data;
               streak_d = '0;
               state_d  = WR_WAIT;
            end
         end
         WR_WAIT: begin
            tmo_en = 1'b1;
            if (ctl_write_done) begin
               cmd_d   = CMD_NOP;
               state_d = GAP;
            end else if (tmo_expired) begin
               cmd_d   = CMD_NOP;
               terr_d  = 1'b1;
               state_d = GAP;
            end
         end
         RD_WAIT: begin
            tmo_en = 1'b1;
            if (ctl_read_valid) begin
               rdata_d = ctl_read;
               rdv_d   = 1'b1;
               cmd_d   = CMD_NOP;
               state_d = GAP;
            end else if (tmo_expired) begin
               cmd_d   = CMD_NOP;
               terr_d  = 1'b1;
               state_d = GAP;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            cmd_d   = CMD_NOP;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         state_q  <= IDLE;
         cmd_q    <= CMD_NOP;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rdv_q    <= 1'b0;
         terr_q   <= 1'b0;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rdv_q    <= rdv_d;
         terr_q   <= terr_d;
         streak_q <= streak_d;
      end
   end

   // Readies are masked while the reset synchronizer is still releasing.
   assign rd_ready      = rd_grant && arb_rst_n;
   assign wr_ready      = wr_grant && arb_rst_n;
   assign ctl_command   = cmd_q;
   assign ctl_address   = addr_q;
   assign ctl_write     = wdata_q;
   assign rd_data       = rdata_q;
   assign rd_data_valid = rdv_q;
   assign timeout_err   = terr_q;

`ifdef FB_ARB_STATS_EN
   logic [31:0] stat_rd_q, stat_wr_q, stat_stall_q;

   always_ff @(posedge clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         stat_rd_q    <= '0;
         stat_wr_q    <= '0;
         stat_stall_q <= '0;
      end else begin
         if (state_q == RD_WAIT && ctl_read_valid) begin
            stat_rd_q <= stat_rd_q + 32'd1;
         end
         if (state_q == WR_WAIT && ctl_write_done) begin
            stat_wr_q <= stat_wr_q + 32'd1;
         end
         if ((wr_valid && !wr_ready) || (rd_valid && !rd_ready)) begin
            stat_stall_q <= stat_stall_q + 32'd1;
         end
      end
   end

   assign stat_reads        = stat_rd_q;
   assign stat_writes       = stat_wr_q;
   assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_fb_arbiter
// Self-checking bench for sdram_fb_arbiter. The bench plays both clients and
// the SDRAM controller; expectations come from a transaction-level model of
// the grant rules (streak count, sticky timeout flag, completion counts).
// Optional build macro: FB_ARB_STATS_EN enables the statistics checks.
// -----------------------------------------------------------------------------
module tb_sdram_fb_arbiter;

   localparam int AW   = 22;
   localparam int DW   = 32;
   localparam int MAXS = 8;
   localparam int TMO  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid = 1'b0, rd_valid = 1'b0;
   logic          wr_ready, rd_ready;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data;
   logic          rd_data_valid, timeout_err;
   logic [1:0]    ctl_command;
   logic [AW-1:0] ctl_address;
   logic [DW-1:0] ctl_write;
   logic [DW-1:0] ctl_read = '0;
   logic          ctl_read_valid = 1'b0, ctl_write_done = 1'b0;
`ifdef FB_ARB_STATS_EN
   logic [31:0]   stat_reads, stat_writes, stat_stall_cycles;
`endif

   always #5 clk = ~clk;

   sdram_fb_arbiter #(
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_READ_STREAK (MAXS),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_data_valid  (rd_data_valid),
      .timeout_err    (timeout_err),
      .ctl_command    (ctl_command),
      .ctl_address    (ctl_address),
      .ctl_write      (ctl_write),
      .ctl_read       (ctl_read),
      .ctl_read_valid (ctl_read_valid),
      .ctl_write_done (ctl_write_done)
`ifdef FB_ARB_STATS_EN
     ,.stat_reads        (stat_reads),
      .stat_writes       (stat_writes),
      .stat_stall_cycles (stat_stall_cycles)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int m_streak = 0;
   bit m_terr   = 1'b0;
   int m_reads  = 0;
   int m_writes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd"},   ctl_command, 0);
      chk({tag, "_addr"},  ctl_address, 0);
      chk({tag, "_wdata"}, ctl_write, 0);
      chk({tag, "_ready"}, {rd_ready, wr_ready}, 0);
      chk({tag, "_rdata"}, rd_data, 0);
      chk({tag, "_rdv"},   rd_data_valid, 0);
      chk({tag, "_terr"},  timeout_err, 0);
   endtask

   // One arbitration opportunity: present the requests in an idle cycle,
   // then, if something is granted, act as the controller until completion
   // (or never respond when hang is set) and check the gap cycle.
   // grant: 0 none / 1 write / 2 read as seen on the DUT readies.
   task automatic run_slot(input bit rv, input bit wv,
                           input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rdat,
                           input int lat, input bit hang,
                           output int grant, output int hold);
      bit            exp_rd, exp_wr;
      logic [AW-1:0] ea;
      @(negedge clk);
      rd_valid = rv; wr_valid = wv;
      rd_addr = ra; wr_addr = wa; wr_data = wd;
      ctl_read_valid = 1'b0; ctl_write_done = 1'b0; ctl_read = DW'($urandom);
      #1;
      exp_rd = rv && (!wv || m_streak < MAXS);
      exp_wr = !exp_rd && wv;
      chk("rd_ready", rd_ready, exp_rd);
      chk("wr_ready", wr_ready, exp_wr);
      chk("idle_cmd", ctl_command, 0);
      chk("idle_rdv", rd_data_valid, 0);
      chk("timeout_err", timeout_err, m_terr);
      grant = rd_ready ? 2 : (wr_ready ? 1 : 0);
      hold  = 0;
      if (exp_rd) m_streak = wv ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      else if (exp_wr) m_streak = 0;
      if (!exp_rd && !exp_wr) return;

      ea = exp_rd ? ra : wa;
      for (int k = 1; k <= TMO + 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (exp_rd) rd_valid = 1'b0;
            else        wr_valid = 1'b0;
         end
         ctl_read_valid = 1'b0; ctl_write_done = 1'b0; ctl_read = DW'($urandom);
         #1;
         if (ctl_command == 2'd0) break;
         hold++;
         chk("wait_cmd", ctl_command, exp_rd ? 2 : 1);
         chk("wait_addr", ctl_address, ea);
         if (exp_wr) chk("wait_wdata", ctl_write, wd);
         chk("wait_ready", {rd_ready, wr_ready}, 0);
         if (!hang && k == lat) begin
            if (exp_rd) begin ctl_read_valid = 1'b1; ctl_read = rdat; end
            else ctl_write_done = 1'b1;
         end else if ($urandom_range(0, 3) == 0) begin
            // stray completion of the other kind must be ignored
            if (exp_rd) ctl_write_done = 1'b1;
            else        ctl_read_valid = 1'b1;
         end
      end
      // gap cycle
      chk("hold_len", hold, hang ? TMO : lat);
      if (hang) m_terr = 1'b1;
      chk("gap_rdv", rd_data_valid, exp_rd && !hang);
      if (exp_rd && !hang) chk("rd_data", rd_data, rdat);
      chk("gap_ready", {rd_ready, wr_ready}, 0);
      chk("gap_terr", timeout_err, m_terr);
      if (!hang) begin
         if (exp_rd) m_reads++;
         else        m_writes++;
      end
      rd_valid = 1'b0; wr_valid = 1'b0;
   endtask

   typedef struct {
      bit            rv;
      bit            wv;
      logic [AW-1:0] ra;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [DW-1:0] rdat;
      int            lat;
      bit            hang;
      int            exp_grant;
      int            exp_hold;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int g, h;
      bit rv, wv;
      logic [AW-1:0] ra, wa;
      logic [DW-1:0] wd;

      vecs[0] = '{1'b0, 1'b1, 22'h000000, 22'h000010, 32'hDEADBEEF, 32'h0,        5, 1'b0, 1, 5};
      vecs[1] = '{1'b1, 1'b0, 22'h3FFFFF, 22'h000000, 32'h0,        32'h12345678, 6, 1'b0, 2, 6};
      vecs[2] = '{1'b0, 1'b0, 22'h000000, 22'h000000, 32'h0,        32'h0,        1, 1'b0, 0, 0};
      vecs[3] = '{1'b1, 1'b1, 22'h000100, 22'h000200, 32'h11112222, 32'hCAFEF00D, 2, 1'b0, 2, 2};
      vecs[4] = '{1'b1, 1'b0, 22'h000000, 22'h000000, 32'h0,        32'h00000001, 1, 1'b0, 2, 1};
      vecs[5] = '{1'b1, 1'b0, 22'h00ABCD, 22'h000000, 32'h0,        32'hBAD0BAD0, 1, 1'b1, 2, TMO};
      vecs[6] = '{1'b0, 1'b1, 22'h000000, 22'h155555, 32'hA5A5A5A5, 32'h0,        3, 1'b0, 1, 3};
      vecs[7] = '{1'b0, 1'b1, 22'h000000, 22'h2AAAAA, 32'h5A5A5A5A, 32'h0,        1, 1'b0, 1, 1};
      vecs[8] = '{1'b1, 1'b1, 22'h001234, 22'h004321, 32'h0BADCAFE, 32'h87654321, 4, 1'b0, 2, 4};

      // reset state, with both clients requesting
      rd_valid = 1'b1; wr_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rd_valid = 1'b0; wr_valid = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // directed table
      for (int i = 0; i < 9; i++) begin
         run_slot(vecs[i].rv, vecs[i].wv, vecs[i].ra, vecs[i].wa, vecs[i].wd,
                  vecs[i].rdat, vecs[i].lat, vecs[i].hang, g, h);
         chk($sformatf("vec%0d_grant", i), g, vecs[i].exp_grant);
         chk($sformatf("vec%0d_hold", i), h, vecs[i].exp_hold);
      end

      // contention: streak cleared by a write, then 8 reads / 1 write repeating
      run_slot(1'b0, 1'b1, '0, 22'h000777, 32'h77777777, '0, 2, 1'b0, g, h);
      for (int i = 0; i < 27; i++) begin
         run_slot(1'b1, 1'b1, AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                  $urandom_range(1, 3), 1'b0, g, h);
         chk($sformatf("contention%0d_grant", i), g, (i % 9 == 8) ? 1 : 2);
      end

      // reset during WR_WAIT
      @(negedge clk);
      wr_valid = 1'b1; rd_valid = 1'b0; wr_addr = 22'h0ABCDE; wr_data = 32'hFEEDFACE;
      #1;
      chk("rstmid_grant", wr_ready, 1);
      @(negedge clk);
      #1;
      chk("rstmid_pre_cmd", ctl_command, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rstmid_async");
      @(negedge clk);
      #1;
      check_reset_outputs("rstmid_held");
      rst_n = 1'b1; wr_valid = 1'b0;
      m_streak = 0; m_terr = 1'b0; m_reads = 0; m_writes = 0;
      repeat (3) @(negedge clk);
      run_slot(1'b0, 1'b1, '0, 22'h0ABCDE, 32'hFEEDFACE, '0, 2, 1'b0, g, h);
      chk("rstmid_after_grant", g, 1);

      // randomized traffic; unaccepted requests stay pending
      rv = 1'b0; wv = 1'b0; ra = '0; wa = '0; wd = '0;
      for (int i = 0; i < 150; i++) begin
         if (!rv && $urandom_range(0, 99) < 60) begin rv = 1'b1; ra = AW'($urandom); end
         if (!wv && $urandom_range(0, 99) < 50) begin wv = 1'b1; wa = AW'($urandom); wd = DW'($urandom); end
         run_slot(rv, wv, ra, wa, wd, DW'($urandom), $urandom_range(1, 6), 1'b0, g, h);
         if (g == 2) rv = 1'b0;
         if (g == 1) wv = 1'b0;
      end

`ifdef FB_ARB_STATS_EN
      @(negedge clk);
      chk("stat_reads", stat_reads, m_reads);
      chk("stat_writes", stat_writes, m_writes);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched so far", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sdram_fb_arbiter.md
Name: sdram_fb_arbiter

Overview:
- Upstream client arbiter for the framebuffer SDRAM controller in the Julia LCD design.
- Merges two clients into the controller's single-command port:
  - the fractal pixel writer (write stream)
  - the LCD scanout prefetcher (read stream)
- Issues one controller command at a time and holds it until completion.
- Returns read data to scanout; gives scanout bounded priority so the pixel writer cannot starve it, and vice versa.

Parameters:
- ADDR_WIDTH, 22, controller word-address width.
- DATA_WIDTH, 32, controller data width.
- MAX_READ_STREAK, 8, consecutive read grants allowed while a write is pending (range 1..255).
- TIMEOUT_CYCLES, 1024, completion-wait limit per command before abort.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  pixel write request
- wr_ready  out  1  write request accepted this cycle
- wr_addr  in  ADDR_WIDTH  write word address
- wr_data  in  DATA_WIDTH  write word
- rd_valid  in  1  scanout read request
- rd_ready  out  1  read request accepted this cycle
- rd_addr  in  ADDR_WIDTH  read word address
- rd_data  out  DATA_WIDTH  returned read word
- rd_data_valid  out  1  one-cycle strobe qualifying rd_data
- timeout_err  out  1  sticky: a command timed out
- ctl_command  out  2  to controller command
- ctl_address  out  ADDR_WIDTH  to controller data_address
- ctl_write  out  DATA_WIDTH  to controller data_write
- ctl_read  in  DATA_WIDTH  from controller data_read
- ctl_read_valid  in  1  from controller data_read_valid
- ctl_write_done  in  1  from controller data_write_done

Behaviour:
- Reset (async assert, sync-to-clk deassert internally), all outputs:
  - ctl_command=CMD_NOP; ctl_address=0; ctl_write=0
  - wr_ready=0; rd_ready=0; rd_data=0; rd_data_valid=0; timeout_err=0
  - streak counter=0; state=IDLE
- Command encoding: NOP=0, WRITE=1, READ=2; 3 is never driven.
- States: IDLE, WR_WAIT, RD_WAIT, GAP.
- IDLE, grant decision:
  - If rd_valid and (!wr_valid or streak<MAX_READ_STREAK): grant read.
    - Pulse rd_ready; latch rd_addr; drive READ.
    - Streak++ if wr_valid, else streak=0.
    - Next state RD_WAIT.
  - Else if wr_valid: grant write.
    - Pulse wr_ready; latch wr_addr/wr_data; drive WRITE; streak=0.
    - Next state WR_WAIT.
  - Else: stay IDLE with NOP.
  - Simultaneous rd_valid and wr_valid with streak==MAX_READ_STREAK: the write wins.
- Ready signals: wr_ready/rd_ready are combinational from state==IDLE plus the grant decision; at most one is high per cycle.
- Command hold: ctl_command/address/write stay registered and stable for the whole WAIT state.
- WR_WAIT: on ctl_write_done, drive NOP → GAP.
- RD_WAIT: on ctl_read_valid:
  - capture ctl_read into rd_data; rd_data_valid=1 the next cycle (1-cycle latency from ctl_read_valid)
  - drive NOP → GAP.
- Stray completions: ctl_read_valid in WR_WAIT and ctl_write_done in RD_WAIT are ignored.
- GAP: exactly one NOP cycle → IDLE. This guarantees the controller sees a command edge between operations.
- Throughput: minimum 3 cycles per request (grant, ≥1 wait, gap) plus controller latency.
- Timeout:
  - Wait counter clears on each grant and increments each WAIT cycle.
  - At TIMEOUT_CYCLES without completion: drive NOP, set timeout_err, → GAP.
  - No rd_data_valid for the aborted read.
  - timeout_err clears only on reset.
- Reset mid-operation: immediate NOP and IDLE; an in-flight request is dropped, and the client must re-issue.
- Streak counter saturates at MAX_READ_STREAK; width = clog2(MAX_READ_STREAK+1).

Optional Feature:
- Macro FB_ARB_STATS_EN.
- Defined: adds outputs stat_reads, stat_writes, stat_stall_cycles (32 bits each, wrap at 2^32, reset 0).
  - stat_reads / stat_writes increment on each completed read/write.
  - stat_stall_cycles increments each cycle wr_valid or rd_valid is high but not accepted.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package sdram_fb_pkg:
  - typedef enum logic [1:0] ctl_cmd_t {CMD_NOP, CMD_WRITE, CMD_READ}
  - typedef enum arb_state_t {IDLE, WR_WAIT, RD_WAIT, GAP}
  - ADDR_WIDTH/DATA_WIDTH defaults
- One sub-module: sdram_fb_arb_timeout (loadable wait counter with expiry flag).

Test Plan:
- Single write: wr_valid, addr 0x000010, data 0xDEADBEEF; controller model asserts write_done after 5 cycles.
  - Required: wr_ready for 1 cycle; ctl_command=1 held 5 cycles, then NOP ≥1 cycle; ctl_address 0x000010; ctl_write 0xDEADBEEF.
- Single read: rd_addr 0x3FFFFF; model returns 0x12345678 with read_valid 6 cycles later.
  - Required: ctl_command=2 held; rd_data 0x12345678 with rd_data_valid one cycle after ctl_read_valid.
- Contention: rd_valid and wr_valid held high continuously, MAX_READ_STREAK=8.
  - Required: grant pattern of 8 reads, 1 write, repeating; never 9 consecutive reads.
- Timeout: read issued, model never responds, TIMEOUT_CYCLES=16.
  - Required: NOP after 16 wait cycles; timeout_err=1; no rd_data_valid; the next write proceeds normally.
- Reset mid-op: rst_n low during WR_WAIT.
  - Required: ctl_command=NOP the same cycle (async), all outputs at reset values, IDLE after release.
- FB_ARB_STATS_EN: 3 writes, 2 reads.
  - Required: stat_writes=3, stat_reads=2.
